vga_fetch: RTL and testbench
============================

# vga_fetch

Frame-buffer read stage directly upstream of `vga_write`. Fetches packed 36-bit words (two 18-bit pixels) from the ZBT frame memory through the memory arbiter, buffers them in a 2-entry FIFO, and presents them on `vga_pixel`/`done_vga` whenever `vga_write` raises `vga_flag`. It selects which ping-pong buffer to display at each frame start.

## Interface

- `ADDR_W`, 19, memory word-address width
- `WORDS_PER_FRAME`, 153600, words per frame (640x480 / 2)
- `BASE_A`, 0, word address of buffer A
- `BASE_B`, 153600, word address of buffer B
- `READ_LATENCY`, 2, cycles from granted request to `mem_data` valid (≥1)

Ports:

- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `frame_flag` in 1: one-cycle pulse at start of output frame (vertical blank).
- `display_sel` in 1: 0 selects buffer A, 1 selects buffer B. Sampled only on `frame_flag`.
- `vga_flag` in 1: consume pulse from `vga_write`. Pops the presented word.
- `vga_pixel` out 36: head-of-FIFO word, `{pixel0[17:0], pixel1[17:0]}`.
- `done_vga` out 1: `vga_pixel` valid.
- `mem_req` out 1: read request to the arbiter.
- `mem_addr` out ADDR_W: read word address, valid while `mem_req` is high.
- `mem_grant` in 1: arbiter accepts the request this cycle.
- `mem_data` in 36: read data, `READ_LATENCY` cycles after grant.
- `underflow` out 1: sticky; set when `vga_flag` arrives while `done_vga` is 0. Cleared by `reset` or `frame_flag`.

## Operation

- **States:**
  - IDLE (after reset, no fetching).
  - FETCH.
  - DONE (frame fully requested).
- **Transitions:**
  - Any state → FETCH on `frame_flag`.
  - FETCH → DONE when request number `WORDS_PER_FRAME` is granted.
  - DONE holds until `frame_flag`.
- **On `frame_flag`:**
  - `base <= display_sel ? BASE_B : BASE_A`.
  - Word offset cleared.
  - FIFO flushed.
  - `epoch` bit toggled.
  - `underflow` cleared.
- **Request issue:**
  - `mem_req = (state==FETCH) && (fifo_count + inflight < 2)`.
  - `mem_addr = base + offset`.
  - On grant: `offset++`, `inflight++`, and the current epoch is pushed into a `READ_LATENCY`-deep valid/epoch shift pipe.
- **Return path:** when the pipe output is valid, `inflight--`. The word is written into the FIFO only if its epoch equals the current epoch; stale returns from before a `frame_flag` are dropped.
- **Occupancy rule:** `fifo_count + inflight ≤ 2` always, so the FIFO never overflows.
- **Pop:** `vga_flag && done_vga` pops the head. Push and pop in the same cycle are both honoured.
- **Ignored inputs:** `vga_flag` with `done_vga` low pops nothing and sets `underflow`. `mem_grant` without `mem_req` is ignored.
- **Width:** `offset` counts 0..`WORDS_PER_FRAME`; address addition is truncated to ADDR_W.

## Timing

- **Reset values:** every output is 0 (`vga_pixel`, `done_vga`, `mem_req`, `mem_addr`, `underflow`). State IDLE, `epoch` 0.
- **Startup latency:**
  - `frame_flag` at cycle N → `mem_req` high at N+1.
  - With immediate grant at N+1 → data returns at N+1+`READ_LATENCY`, is registered into the FIFO, and `done_vga` rises at N+2+`READ_LATENCY` (N+4 at default).
- **Sustained rate:** one word per cycle under continuous grant and continuous `vga_flag`.
- **Simultaneous events:**
  - `frame_flag` together with `vga_flag`: `frame_flag` wins; the flush discards the pop.
  - `frame_flag` together with `mem_grant`: the grant is counted against the old epoch and its data is dropped.
- **`reset` mid-frame:**
  - In-flight pipe cleared.
  - Any later `mem_data` is ignored because its pipe valid bit is 0.

## Structure

- Shared package `vga_pkg`:
  - `PIXEL_W=18`, `WORD_W=36`.
  - Frame geometry constants (`H_ACTIVE=640`, `V_ACTIVE=480`, `WORDS_PER_FRAME`).
  - Buffer base constants.
- One natural sub-module: `fifo2`, a 2-entry synchronous FIFO with flush, count, push, pop and head output.
- Epoch/valid shift pipe and FSM stay in `vga_fetch`.

## Test plan

- **Reset then single frame:** reset, `display_sel=0`, `frame_flag` pulse, `mem_grant` tied 1, model memory returns `mem_data=addr`. Require:
  - first `mem_addr=0`;
  - `done_vga` at frame_flag+4 with `vga_pixel=0`;
  - 153600 pops yield 0..153599 in order;
  - then `mem_req` stays 0.
- **Buffer B:** `display_sel=1` → first `mem_addr=153600`, last `mem_addr=307199`.
- **Backpressure:** hold `vga_flag=0` → at most 2 grants, `mem_req` drops, FIFO holds words 0,1. One pop → exactly one new request, for address 2.
- **Arbiter stall:** `mem_grant` low 10 cycles mid-frame, continuous `vga_flag` → `underflow` sets. Order stays contiguous, with no skipped or duplicated words.
- **Mid-frame `frame_flag`:** pulse with 2 reads in flight and `display_sel` flipped → stale data dropped, first word presented equals the new base, `underflow` cleared.
- **Reset mid-frame:** all outputs 0 next cycle. Late `mem_data` is not presented. `mem_req` stays 0 until the next `frame_flag`.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer read path.
// Geometry, buffer bases and the fetch FSM state encoding live here.
package vga_pkg;

  localparam int PIXEL_W     = 18;
  localparam int WORD_W      = 2 * PIXEL_W;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / 2;
  localparam int BUF_A_BASE  = 0;
  localparam int BUF_B_BASE  = FRAME_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vga_fetch_fifo2.sv
// Two-entry synchronous FIFO with flush; head is presented combinationally.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fifo2
  import vga_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] slot_reg [2];
  logic              rd_ptr_reg;
  logic              wr_ptr_reg;
  logic [1:0]        count_reg;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clock) begin
        if (reset) begin
          slot_reg[gi] <= '0;
        end else if (!flush && do_push && (wr_ptr_reg == gi[0])) begin
          slot_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = slot_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/vga_fetch.sv
// Frame-buffer fetch: requests words through the arbiter, tags each grant with an epoch,
// drops returns from a previous frame and presents surviving words to vga_write.
module vga_fetch
  import vga_pkg::*;
#(
  parameter int ADDR_W          = 19,
  parameter int WORDS_PER_FRAME = FRAME_WORDS,
  parameter int BASE_A          = BUF_A_BASE,
  parameter int BASE_B          = BUF_B_BASE,
  parameter int READ_LATENCY    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_flag,
  input  logic              display_sel,
  input  logic              vga_flag,
  output logic [WORD_W-1:0] vga_pixel,
  output logic              done_vga,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic [WORD_W-1:0] mem_data,
  output logic              underflow
);

  localparam int OFF_W = $clog2(WORDS_PER_FRAME + 1);

  fetch_state_t            state_reg;
  fetch_state_t            state_next;
  logic [OFF_W-1:0]        offset_reg;
  logic [ADDR_W-1:0]       base_reg;
  logic                    epoch_reg;
  logic [1:0]              inflight_reg;
  logic                    underflow_reg;
  logic [READ_LATENCY-1:0] pipe_valid_reg;
  logic [READ_LATENCY-1:0] pipe_epoch_reg;

  logic [1:0]        fifo_count;
  logic [WORD_W-1:0] fifo_head;
  logic              grant_ok;
  logic              last_grant;
  logic              ret_valid;
  logic              fifo_push;
  logic              fifo_pop;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (frame_flag)                             state_next = ST_FETCH;
    else if (state_reg == ST_FETCH && last_grant) state_next = ST_DONE;
  end

  // Requests are throttled so buffered plus outstanding words never exceed the FIFO depth.
  always_comb begin
    mem_req  = (state_reg == ST_FETCH) && (({1'b0, fifo_count} + {1'b0, inflight_reg}) < 3'd2);
    grant_ok = mem_req && mem_grant;
  end

  assign last_grant = grant_ok && (offset_reg == OFF_W'(WORDS_PER_FRAME - 1));
  assign mem_addr   = base_reg + ADDR_W'(offset_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      base_reg      <= '0;
      offset_reg    <= '0;
      epoch_reg     <= 1'b0;
      inflight_reg  <= 2'd0;
      underflow_reg <= 1'b0;
    end else begin
      inflight_reg <= inflight_reg + {1'b0, grant_ok} - {1'b0, ret_valid};
      if (frame_flag) begin
        base_reg      <= display_sel ? ADDR_W'(BASE_B) : ADDR_W'(BASE_A);
        offset_reg    <= '0;
        epoch_reg     <= ~epoch_reg;
        underflow_reg <= 1'b0;
      end else begin
        if (grant_ok)              offset_reg    <= offset_reg + 1'b1;
        if (vga_flag && !done_vga) underflow_reg <= 1'b1;
      end
    end
  end

  // A grant in the frame_flag cycle still carries the old epoch, so its data is discarded.
  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clock) begin
          if (reset) begin
            pipe_valid_reg[0] <= 1'b0;
            pipe_epoch_reg[0] <= 1'b0;
          end else begin
            pipe_valid_reg[0] <= grant_ok;
            pipe_epoch_reg[0] <= epoch_reg;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clock) begin
          if (reset) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_epoch_reg[gi] <= 1'b0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_epoch_reg[gi] <= pipe_epoch_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign ret_valid = pipe_valid_reg[READ_LATENCY-1];
  assign fifo_push = ret_valid && (pipe_epoch_reg[READ_LATENCY-1] == epoch_reg) && !frame_flag;
  assign fifo_pop  = vga_flag && done_vga && !frame_flag;

  fifo2 u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (frame_flag),
    .push      (fifo_push),
    .push_data (mem_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign done_vga  = (fifo_count != 2'd0);
  assign vga_pixel = fifo_head;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_vga_fetch.sv
// Bench for vga_fetch: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of requests, returns and the presented word stream.
module tb_vga_fetch;

  localparam int ADDR_W = 19;
  localparam int WPF    = 48;
  localparam int BASE_A = 0;
  localparam int BASE_B = 48;
  localparam int LAT    = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              frame_flag = 1'b0;
  logic              display_sel = 1'b0;
  logic              vga_flag = 1'b0;
  logic              mem_grant = 1'b0;
  logic [35:0]       mem_data = '0;
  logic [35:0]       vga_pixel;
  logic              done_vga;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  vga_fetch #(
    .ADDR_W(ADDR_W), .WORDS_PER_FRAME(WPF), .BASE_A(BASE_A), .BASE_B(BASE_B), .READ_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag), .display_sel(display_sel),
    .vga_flag(vga_flag), .vga_pixel(vga_pixel), .done_vga(done_vga), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_grant(mem_grant), .mem_data(mem_data), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: returns the granted address as data LAT cycles later, junk otherwise.
  logic [35:0] mem_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) mem_pipe[i] = '0;
  always @(posedge clock) begin
    logic              took;
    logic [ADDR_W-1:0] a;
    took = mem_req && mem_grant;
    a    = mem_addr;
    #1;
    for (int i = LAT - 1; i > 0; i--) mem_pipe[i] = mem_pipe[i-1];
    mem_pipe[0] = took ? 36'(a) : {4'hF, 32'($urandom)};
    mem_data = mem_pipe[LAT-1];
  end

  // Reference model: outstanding reads tagged with frame number, FIFO as a queue.
  typedef struct {
    int unsigned due;
    int unsigned frame;
    logic [35:0] word;
  } pend_t;

  pend_t             pend_q[$];
  logic [35:0]       mfifo[$];
  int unsigned       cyc = 0;
  int unsigned       m_frame = 0;
  int unsigned       m_granted = 0;
  logic [ADDR_W-1:0] m_base = '0;
  bit                m_active = 0;
  bit                m_under = 0;
  bit                model_ok = 0;

  function automatic bit f_req();
    return m_active && ((mfifo.size() + pend_q.size()) < 2);
  endfunction

  function automatic logic [ADDR_W-1:0] f_addr();
    return m_base + ADDR_W'(m_granted);
  endfunction

  always @(posedge clock) begin
    bit    g;
    bit    empty_now;
    pend_t p;
    if (reset) begin
      pend_q.delete();
      mfifo.delete();
      m_active  = 0;
      m_under   = 0;
      m_base    = '0;
      m_granted = 0;
      model_ok  = 1;
    end else if (model_ok) begin
      g         = f_req() && mem_grant;
      empty_now = (mfifo.size() == 0);
      if (vga_flag && !empty_now && !frame_flag) void'(mfifo.pop_front());
      while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        if (p.frame == m_frame && !frame_flag) mfifo.push_back(p.word);
      end
      if (frame_flag)                  m_under = 0;
      else if (vga_flag && empty_now)  m_under = 1;
      if (g) begin
        pend_q.push_back('{cyc + LAT, m_frame, 36'(f_addr())});
        m_granted++;
        if (m_granted == WPF) m_active = 0;
      end
      if (frame_flag) begin
        m_frame++;
        m_base    = display_sel ? ADDR_W'(BASE_B) : ADDR_W'(BASE_A);
        m_granted = 0;
        mfifo.delete();
        m_active  = 1;
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (model_ok && !reset) begin
      check("mem_req", mem_req, f_req());
      if (f_req()) check("mem_addr", mem_addr, f_addr());
      check("done_vga", done_vga, mfifo.size() > 0);
      if (mfifo.size() > 0) check("vga_pixel", vga_pixel, mfifo[0]);
      check("underflow", underflow, m_under);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  initial begin
    int npop;
    int ngr;
    int bad;
    logic [35:0]       last_word;
    logic [ADDR_W-1:0] last_addr;

    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_done_vga", done_vga, 0);
    check("rst_vga_pixel", vga_pixel, 0);
    check("rst_underflow", underflow, 0);
    cycles(2);

    // Buffer A, full frame, continuous grant and consume.
    display_sel = 1'b0; mem_grant = 1'b1; vga_flag = 1'b1; frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    check("a_first_req", mem_req, 1);
    check("a_first_addr", mem_addr, BASE_A);
    cycles(2);
    check("a_done_n3", done_vga, 0);
    step();
    check("a_done_n4", done_vga, 1);
    check("a_first_pixel", vga_pixel, 0);
    npop = 0; last_word = '0;
    for (int i = 0; i < 200 && npop < WPF; i++) begin
      if (done_vga && vga_flag) begin
        last_word = vga_pixel;
        npop++;
      end
      step();
    end
    check("a_pop_count", npop, WPF);
    check("a_last_word", last_word, WPF - 1);
    cycles(10);
    check("a_req_after_frame", mem_req, 0);

    // Buffer B.
    display_sel = 1'b1; frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    check("b_first_addr", mem_addr, BASE_B);
    ngr = 0; last_addr = '0;
    for (int i = 0; i < 200 && ngr < WPF; i++) begin
      if (mem_req && mem_grant) begin
        last_addr = mem_addr;
        ngr++;
      end
      step();
    end
    check("b_grant_count", ngr, WPF);
    check("b_last_addr", last_addr, BASE_B + WPF - 1);
    cycles(6);

    // Backpressure: no consumption.
    vga_flag = 1'b0; display_sel = 1'b0; frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    ngr = 0;
    repeat (12) begin
      if (mem_req && mem_grant) ngr++;
      step();
    end
    check("bp_grants", ngr, 2);
    check("bp_req_low", mem_req, 0);
    check("bp_done", done_vga, 1);
    check("bp_head", vga_pixel, 0);
    vga_flag = 1'b1;
    step();
    vga_flag = 1'b0;
    check("bp_head_after_pop", vga_pixel, 1);
    ngr = 0; last_addr = '0;
    repeat (8) begin
      if (mem_req && mem_grant) begin
        ngr++;
        last_addr = mem_addr;
      end
      step();
    end
    check("bp_refill_grants", ngr, 1);
    check("bp_refill_addr", last_addr, 2);

    // Arbiter stall with continuous consumption.
    vga_flag = 1'b1;
    cycles(4);
    mem_grant = 1'b0;
    cycles(10);
    check("stall_underflow", underflow, 1);
    mem_grant = 1'b1;
    cycles(8);

    // Mid-frame restart onto buffer B with reads in flight.
    display_sel = 1'b1; frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    check("mf_underflow_clr", underflow, 0);
    for (int i = 0; i < 20 && !done_vga; i++) step();
    check("mf_data_arrives", done_vga, 1);
    check("mf_first_word", vga_pixel, BASE_B);
    cycles(3);

    // Reset mid-frame.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_mem_req", mem_req, 0);
    check("mr_mem_addr", mem_addr, 0);
    check("mr_done_vga", done_vga, 0);
    check("mr_vga_pixel", vga_pixel, 0);
    check("mr_underflow", underflow, 0);
    bad = 0;
    repeat (10) begin
      if (mem_req || done_vga) bad++;
      step();
    end
    check("mr_quiet", bad, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      mem_grant   = ($urandom_range(0, 9) < 7);
      vga_flag    = ($urandom_range(0, 9) < 6);
      display_sel = 1'($urandom_range(0, 1));
      frame_flag  = ($urandom_range(0, 79) == 0);
      reset       = ($urandom_range(0, 799) == 0) && !frame_flag;
      step();
    end
    reset = 1'b0; frame_flag = 1'b0; vga_flag = 1'b0; mem_grant = 1'b0;
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
